trace_capture_unit: RTL and testbench

//  Synthesizable, parametrised successor to the bench-only PC/IR monitor.

---
 rtl/trace_capture_unit.sv | 216 +++++++++++++++++++++
 tb/tb_trace_capture_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture_unit.sv
// Trace capture unit: records time-stamped samples into a circular buffer around
// a value/mask trigger and plays the captured window back oldest-first.
module trace_capture_unit #(
  parameter int DATA_W       = 24,
  parameter int TS_W         = 16,
  parameter int DEPTH        = 16,
  parameter int POST_SAMPLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       sample_valid,
  input  logic [DATA_W-1:0]          sample_data,
  input  logic [DATA_W-1:0]          trig_value,
  input  logic [DATA_W-1:0]          trig_mask,
  input  logic                       force_trig,
  input  logic                       rd_en,
  output logic [TS_W+DATA_W-1:0]     rd_data,
  output logic                       rd_valid,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH):0]     words_avail,
  output logic                       wrapped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TS_W + DATA_W;

  localparam logic [CW-1:0]   FULL_C    = CW'(DEPTH);
  localparam logic [CW-1:0]   POST_C    = CW'(POST_SAMPLES);
  localparam logic [CW-1:0]   CNT_ONE_C = CW'(1);
  localparam logic [AW-1:0]   PTR_ONE_C = AW'(1);
  localparam logic [TS_W-1:0] TS_ONE_C  = TS_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [TS_W-1:0] ts_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   fill_r;
  logic [CW-1:0]   post_cnt_r;
  logic            wrapped_r;
  logic [EW-1:0]   rd_data_r;
  logic            rd_valid_r;
  logic [EW-1:0]   mem_r [DEPTH];

  logic            hit_s;
  logic            wr_en_s;
  logic            rd_fire_s;
  logic            post_load_s;
  logic            done_load_s;
  logic            fill_full_s;
  logic [CW-1:0]   fill_inc_s;
  logic [AW-1:0]   wr_ptr_inc_s;
  logic [AW-1:0]   done_rd_ptr_s;

  assign hit_s = sample_valid &
                 (force_trig | (((sample_data ^ trig_value) & trig_mask) == {DATA_W{1'b0}}));

  // Saturating fill and the read pointer that points at the oldest entry once capture ends.
  always_comb begin
    fill_full_s  = (fill_r == FULL_C);
    wr_ptr_inc_s = wr_ptr_r + PTR_ONE_C;
    if (fill_full_s) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + CNT_ONE_C;
    end
    done_rd_ptr_s = wr_ptr_inc_s - fill_inc_s[AW-1:0];
  end

  // Next-state and per-cycle control; arm overrides samples and reads.
  always_comb begin
    state_next_s = state_r;
    wr_en_s      = 1'b0;
    rd_fire_s    = 1'b0;
    post_load_s  = 1'b0;
    done_load_s  = 1'b0;
    if (arm) begin
      state_next_s = ST_ARMED;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_next_s = ST_IDLE;
        end
        ST_ARMED: begin
          if (sample_valid) begin
            wr_en_s = 1'b1;
            if (hit_s) begin
              if (POST_SAMPLES == 0) begin
                state_next_s = ST_DONE;
                done_load_s  = 1'b1;
              end else begin
                state_next_s = ST_POST;
                post_load_s  = 1'b1;
              end
            end else begin
              state_next_s = ST_ARMED;
            end
          end else begin
            state_next_s = ST_ARMED;
          end
        end
        ST_POST: begin
          if (sample_valid) begin
            wr_en_s = 1'b1;
            if (post_cnt_r == CNT_ONE_C) begin
              state_next_s = ST_DONE;
              done_load_s  = 1'b1;
            end else begin
              state_next_s = ST_POST;
            end
          end else begin
            state_next_s = ST_POST;
          end
        end
        ST_DONE: begin
          if (rd_en && (fill_r != {CW{1'b0}})) begin
            rd_fire_s = 1'b1;
          end else begin
            rd_fire_s = 1'b0;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Free-running timestamp shared by all entries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_ONE_C;
    end
  end

  // Capture storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {ts_r, sample_data};
    end
  end

  // Pointers, fill/words counter, post-trigger count and wrap flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fill_r     <= {CW{1'b0}};
      post_cnt_r <= {CW{1'b0}};
      wrapped_r  <= 1'b0;
    end else if (arm) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fill_r     <= {CW{1'b0}};
      post_cnt_r <= {CW{1'b0}};
      wrapped_r  <= 1'b0;
    end else if (wr_en_s) begin
      wr_ptr_r <= wr_ptr_inc_s;
      fill_r   <= fill_inc_s;
      if (fill_full_s) begin
        wrapped_r <= 1'b1;
      end
      if (post_load_s) begin
        post_cnt_r <= POST_C;
      end else if (state_r == ST_POST) begin
        post_cnt_r <= post_cnt_r - CNT_ONE_C;
      end
      if (done_load_s) begin
        rd_ptr_r <= done_rd_ptr_s;
      end
    end else if (rd_fire_s) begin
      rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      fill_r   <= fill_r - CNT_ONE_C;
    end
  end

  // Registered readout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r  <= {EW{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_fire_s;
      if (rd_fire_s) begin
        rd_data_r <= mem_r[rd_ptr_r];
      end
    end
  end

  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign state       = state_r;
  assign words_avail = fill_r;
  assign wrapped     = wrapped_r;

endmodule

// File: tb/tb_trace_capture_unit.sv
// Self-checking bench for trace_capture_unit: queue-based window model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_trace_capture_unit;

  localparam int DATA_W = 24;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 16;
  localparam int POST   = 4;
  localparam int EW     = TS_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              arm = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic [DATA_W-1:0] trig_value = '0;
  logic [DATA_W-1:0] trig_mask = '0;
  logic              force_trig = 1'b0;
  logic              rd_en = 1'b0;
  logic [EW-1:0]     rd_data;
  logic              rd_valid;
  logic [1:0]        state;
  logic [4:0]        words_avail;
  logic              wrapped;

  int checks = 0;
  int failures = 0;

  trace_capture_unit #(
    .DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH), .POST_SAMPLES(POST)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .sample_valid(sample_valid),
    .sample_data(sample_data), .trig_value(trig_value), .trig_mask(trig_mask),
    .force_trig(force_trig), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .state(state), .words_avail(words_avail), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the window is a queue of the last DEPTH {ts,payload} entries.
  int            m_state = 0;
  logic [EW-1:0] m_q[$];
  logic          m_wrapped = 1'b0;
  logic          m_rd_valid = 1'b0;
  logic [EW-1:0] m_rd_data = '0;
  int            m_post = 0;
  logic [15:0]   m_ts = '0;
  bit            m_hit;

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_state = 0; m_q.delete(); m_wrapped = 1'b0; m_rd_valid = 1'b0;
      m_rd_data = '0; m_post = 0; m_ts = '0;
    end else begin
      m_rd_valid = 1'b0;
      m_hit = sample_valid && (force_trig || (((sample_data ^ trig_value) & trig_mask) == 24'd0));
      if (arm) begin
        m_state = 1; m_q.delete(); m_wrapped = 1'b0;
      end else if ((m_state == 1 || m_state == 2) && sample_valid) begin
        m_q.push_back({m_ts, sample_data});
        if (m_q.size() > DEPTH) begin
          void'(m_q.pop_front());
          m_wrapped = 1'b1;
        end
        if (m_state == 1) begin
          if (m_hit) begin
            if (POST == 0) m_state = 3;
            else begin m_state = 2; m_post = POST; end
          end
        end else begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
      end else if (m_state == 3 && rd_en && m_q.size() > 0) begin
        m_rd_data = m_q.pop_front();
        m_rd_valid = 1'b1;
      end
      m_ts = m_ts + 16'd1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("state", 64'(state), 64'(m_state));
    chk("words_avail", 64'(words_avail), (m_state == 0) ? 64'd0 : 64'(m_q.size()));
    chk("wrapped", 64'(wrapped), 64'(m_wrapped));
    chk("rd_valid", 64'(rd_valid), 64'(m_rd_valid));
    if (m_rd_valid) chk("rd_data", 64'(rd_data), 64'(m_rd_data));
  end

  task automatic cyc(input logic a, input logic sv, input logic [23:0] d,
                     input logic ft, input logic re);
    arm = a; sample_valid = sv; sample_data = d; force_trig = ft; rd_en = re;
    @(posedge clk);
    #1;
    arm = 1'b0; sample_valid = 1'b0; sample_data = '0; force_trig = 1'b0; rd_en = 1'b0;
  endtask

  logic [15:0] prev_ts;
  int gaps[4] = '{3, 1, 2, 4};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_words", 64'(words_avail), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    rst = 1'b1;

    // Wrap scenario, then underflow.
    trig_value = 24'h000014; trig_mask = 24'hFFFFFF;
    cyc(1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cyc(1'b0, 1'b1, 24'(i), 1'b0, 1'b0);
    chk("wrap_state", 64'(state), 64'd3);
    chk("wrap_wrapped", 64'(wrapped), 64'd1);
    chk("wrap_words", 64'(words_avail), 64'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 24'd0, 1'b0, 1'b1);
      chk("wrap_rd_valid", 64'(rd_valid), 64'd1);
      chk("wrap_payload", 64'(rd_data[23:0]), 64'(i + 9));
      if (i > 0) chk("wrap_ts_step", 64'(rd_data[39:24]), 64'(prev_ts + 16'd1));
      prev_ts = rd_data[39:24];
    end
    cyc(1'b0, 1'b0, 24'd0, 1'b0, 1'b1);
    chk("under_rd_valid", 64'(rd_valid), 64'd0);
    chk("under_words", 64'(words_avail), 64'd0);

    // Early trigger.
    trig_value = 24'h000003;
    cyc(1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 24'(i), 1'b0, 1'b0);
    chk("early_state", 64'(state), 64'd3);
    chk("early_wrapped", 64'(wrapped), 64'd0);
    chk("early_words", 64'(words_avail), 64'd8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 24'd0, 1'b0, 1'b1);
      chk("early_payload", 64'(rd_data[23:0]), 64'(i));
    end

    // Mask compare and force trigger.
    trig_value = 24'h000010; trig_mask = 24'h0000FF;
    cyc(1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 24'h123411, 1'b0, 1'b0);
    chk("mask_miss", 64'(state), 64'd1);
    cyc(1'b0, 1'b1, 24'h123410, 1'b0, 1'b0);
    chk("mask_hit", 64'(state), 64'd2);
    cyc(1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 24'd0, 1'b1, 1'b0);
    chk("force_no_valid", 64'(state), 64'd1);
    cyc(1'b0, 1'b1, 24'h555555, 1'b1, 1'b0);
    chk("force_hit", 64'(state), 64'd2);

    // Priority: arm drops a same-cycle sample; arm during POST restarts.
    cyc(1'b1, 1'b1, 24'h000010, 1'b0, 1'b0);
    chk("arm_drop_state", 64'(state), 64'd1);
    chk("arm_drop_words", 64'(words_avail), 64'd0);
    cyc(1'b0, 1'b1, 24'h000010, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 24'h000007, 1'b0, 1'b0);
    chk("post_words", 64'(words_avail), 64'd2);
    cyc(1'b1, 1'b1, 24'h000010, 1'b0, 1'b0);
    chk("rearm_state", 64'(state), 64'd1);
    chk("rearm_words", 64'(words_avail), 64'd0);

    // Reset mid-POST.
    cyc(1'b0, 1'b1, 24'h000010, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 24'h000005, 1'b0, 1'b0);
    chk("pre_rst_state", 64'(state), 64'd2);
    rst = 1'b0;
    #2;
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("mid_rst_words", 64'(words_avail), 64'd0);
    chk("mid_rst_wrapped", 64'(wrapped), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Timestamp restart and gapped samples.
    cyc(1'b1, 1'b0, 24'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 24'h0000A0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      repeat (gaps[k] - 1) cyc(1'b0, 1'b0, 24'd0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 24'(8'hA1 + k), 1'b0, 1'b0);
    end
    chk("gap_state", 64'(state), 64'd3);
    chk("gap_words", 64'(words_avail), 64'd5);
    cyc(1'b0, 1'b0, 24'd0, 1'b0, 1'b1);
    chk("ts_restart", 64'(rd_data[39:24]), 64'd1);
    prev_ts = rd_data[39:24];
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 24'd0, 1'b0, 1'b1);
      chk("gap_ts_delta", 64'(rd_data[39:24] - prev_ts), 64'(gaps[k]));
      prev_ts = rd_data[39:24];
    end

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
